// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises parallel words MSB-first onto a single bit
// stream for a downstream sequence detector. After each word it inserts
// GAP idle cycles before returning to IDLE for the next handshake.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   data_in     word to transmit (MSB first)
//   data_valid  data_in holds a word; only honoured in IDLE
//   data_ready  high in IDLE; a word is accepted when valid && ready
//   n           serial bit stream, 0 when no payload bit is present
//   bit_valid   n carries a payload bit this cycle
//   done        pulses with the last bit of a word
//   busy        high in SHIFT and GAP
//   words_sent  completed-word count, wraps 255 -> 0
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             n,
  output logic             bit_valid,
  output logic             done,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP != 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       words_q, words_d;
  logic             ready_q, ready_d;
  logic             n_q, n_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      words_q     <= 8'd0;
      ready_q     <= 1'b1;
      n_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      words_q     <= words_d;
      ready_q     <= ready_d;
      n_q         <= n_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; outputs are computed from the next state so that
  // they appear registered in the same cycle the state takes effect.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    words_d   = words_q;

    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          words_d   = words_q + 8'd1;
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP != 0) ? S_GAP : S_IDLE;
        end else begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    bit_valid_d = (state_d == S_SHIFT);
    n_d         = bit_valid_d & shift_d[WIDTH-1];
    done_d      = bit_valid_d && (bit_cnt_d == BIT_LAST);
  end

  assign data_ready = ready_q;
  assign n          = n_q;
  assign bit_valid  = bit_valid_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: an 8-bit/GAP=1 instance for the main
// handshake, serialisation, reset and wrap behaviour, and a 4-bit/GAP=0
// instance feeding a 1011 sequence detector.
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, n, bit_valid, done, busy;
  logic [7:0] words_sent;

  logic [3:0] data_in4;
  logic       data_valid4;
  logic       data_ready4, n4, bit_valid4, done4, busy4;
  logic [7:0] words_sent4;

  int         n_assert;
  int         n_fail;
  logic [7:0] exp_words;

  seq_pattern_tx #(.WIDTH(8), .GAP(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .n          (n),
    .bit_valid  (bit_valid),
    .done       (done),
    .busy       (busy),
    .words_sent (words_sent)
  );

  seq_pattern_tx #(.WIDTH(4), .GAP(0)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in4),
    .data_valid (data_valid4),
    .data_ready (data_ready4),
    .n          (n4),
    .bit_valid  (bit_valid4),
    .done       (done4),
    .busy       (busy4),
    .words_sent (words_sent4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 1011 detector on the 4-bit instance's stream
  logic [2:0] hist_q;
  logic       det;
  always_ff @(posedge clk) begin
    if (!reset)          hist_q <= 3'b000;
    else if (bit_valid4) hist_q <= {hist_q[1:0], n4};
  end
  assign det = bit_valid4 && ({hist_q, n4} == 4'b1011);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word from an IDLE negedge; returns at the following IDLE negedge.
  // With noisy set, data_valid/data_in are scrambled while the word shifts.
  task automatic send_word(input logic [7:0] w, input bit noisy);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bit%0d_n w=%02h", i, w), 32'(n), 32'(w[7-i]));
      chk($sformatf("bit%0d_valid", i), 32'(bit_valid), 32'd1);
      chk($sformatf("bit%0d_done", i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("bit%0d_ready", i), 32'(data_ready), 32'd0);
      chk($sformatf("bit%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("bit%0d_words", i), 32'(words_sent), 32'(exp_words));
      if (noisy) begin
        data_valid = i[0];
        data_in    = w ^ 8'(i + 1);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    exp_words  = exp_words + 8'd1;
    chk("gap_n", 32'(n), 32'd0);
    chk("gap_valid", 32'(bit_valid), 32'd0);
    chk("gap_done", 32'(done), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_ready", 32'(data_ready), 32'd0);
    chk("gap_words", 32'(words_sent), 32'(exp_words));
    @(negedge clk);
    chk("idle_ready", 32'(data_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(bit_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] w1, w2, wr;
    logic [3:0] pat;
    n_assert    = 0;
    n_fail      = 0;
    exp_words   = 8'd0;
    reset       = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    data_in4    = 4'h0;
    data_valid4 = 1'b0;

    // Reset, with data_valid asserted during reset being ignored
    repeat (2) @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_n", 32'(n), 32'd0);
    chk("rst_valid", 32'(bit_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_words", 32'(words_sent), 32'd0);
    chk("rst4_ready", 32'(data_ready4), 32'd1);
    chk("rst4_busy", 32'(busy4), 32'd0);
    data_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single word 1011_0110
    send_word(8'b1011_0110, 1'b0);

    // Back-to-back with data_valid held high: second accept 10 cycles later
    w1         = 8'hC3;
    w2         = 8'h5A;
    data_in    = w1;
    data_valid = 1'b1;
    @(negedge clk);
    data_in = w2;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) begin
        chk($sformatf("b2b_c%0d_n", c), 32'(n), 32'(w1[8-c]));
        chk($sformatf("b2b_c%0d_valid", c), 32'(bit_valid), 32'd1);
      end else if (c == 9) begin
        chk("b2b_gap_n", 32'(n), 32'd0);
        chk("b2b_gap_valid", 32'(bit_valid), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
      end else begin
        chk("b2b_idle_valid", 32'(bit_valid), 32'd0);
        chk("b2b_idle_ready", 32'(data_ready), 32'd1);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_w2_bit%0d_n", i), 32'(n), 32'(w2[7-i]));
      chk($sformatf("b2b_w2_bit%0d_valid", i), 32'(bit_valid), 32'd1);
      @(negedge clk);
    end
    exp_words = exp_words + 8'd2;
    chk("b2b_words", 32'(words_sent), 32'(exp_words));
    @(negedge clk);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Input noise during SHIFT must not disturb the word or cause an accept
    send_word(8'h96, 1'b1);
    @(negedge clk);
    chk("noisy_no_extra_busy", 32'(busy), 32'd0);
    chk("noisy_no_extra_words", 32'(words_sent), 32'(exp_words));

    // 256 words from a cleared counter: 255 after word 255, 0 after word 256
    reset = 1'b0;
    @(negedge clk);
    chk("wrap_rst_words", 32'(words_sent), 32'd0);
    reset     = 1'b1;
    exp_words = 8'd0;
    for (int k = 1; k <= 256; k++) begin
      wr = 8'($urandom_range(0, 255));
      send_word(wr, 1'b0);
      if (k == 255) chk("wrap_255", 32'(words_sent), 32'd255);
      if (k == 256) chk("wrap_0", 32'(words_sent), 32'd0);
    end

    // Reset during the 4th bit aborts the word
    data_in    = 8'hE7;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_bit4_n", 32'(n), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_n", 32'(n), 32'd0);
    chk("abort_valid", 32'(bit_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(data_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_words", 32'(words_sent), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_after_done", 32'(done), 32'd0);
    chk("abort_after_busy", 32'(busy), 32'd0);

    // Two 1011 words (WIDTH=4, GAP=0) through the detector
    pat         = 4'b1011;
    data_in4    = pat;
    data_valid4 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) begin
        chk("det_idle_ready", 32'(data_ready4), 32'd1);
        chk("det_idle_valid", 32'(bit_valid4), 32'd0);
        chk("det_idle_det", 32'(det), 32'd0);
      end else begin
        int i;
        i = (c < 5) ? c - 1 : c - 6;
        chk($sformatf("det_c%0d_n", c), 32'(n4), 32'(pat[3-i]));
        chk($sformatf("det_c%0d_valid", c), 32'(bit_valid4), 32'd1);
        chk($sformatf("det_c%0d_det", c), 32'(det), (i == 3) ? 32'd1 : 32'd0);
      end
      if (c == 6) data_valid4 = 1'b0;
      @(negedge clk);
    end
    chk("det_end_busy", 32'(busy4), 32'd0);
    chk("det_end_det", 32'(det), 32'd0);
    chk("det_end_words", 32'(words_sent4), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8, meaning bits per word shifted out.
REQ-002 Parameter GAP, default 1, meaning idle cycles inserted after each word (legal range 0..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low; sampled on rising clk edge.
REQ-005 data_in  input  WIDTH  parallel word to transmit, MSB sent first.
REQ-006 data_valid  input  1  data_in holds a word to send.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 n  output  1  serial bit stream for the downstream sequence detector.
REQ-009 bit_valid  output  1  n carries a payload bit this cycle.
REQ-010 done  output  1  single-cycle pulse coincident with the last bit of a word.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 words_sent  output  8  count of completed words; wraps 255 -> 0.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, GAP; state register plus shift register, bit counter and gap counter are registered.
REQ-014 Handshake: word accepted on a rising edge where data_valid=1 and data_ready=1; data_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance, data_in SHALL be captured into the shift register and the FSM SHALL enter SHIFT; data_in changes after acceptance SHALL have no effect.
REQ-016 Latency: first payload bit (data_in[WIDTH-1]) SHALL appear on n in the cycle immediately after the accepting edge.
REQ-017 In SHIFT, n SHALL present one bit per cycle MSB-first for exactly WIDTH cycles with bit_valid=1.
REQ-018 done SHALL be 1 only during the WIDTH-th SHIFT cycle; words_sent SHALL increment on the edge ending that cycle.
REQ-019 After the last bit: GAP>0 -> enter GAP for exactly GAP cycles; GAP=0 -> return directly to IDLE.
REQ-020 In GAP and IDLE, n SHALL be 0 and bit_valid SHALL be 0.
REQ-021 GAP -> IDLE after the final gap cycle; minimum spacing between consecutive accepts = WIDTH+GAP+1 cycles.
REQ-022 data_valid while busy SHALL be ignored (no capture, no queueing); upstream holds it until data_ready=1.
REQ-023 words_sent at 255 SHALL wrap to 0 on the next completed word with no other side effect.
REQ-024 busy SHALL be 1 in SHIFT and GAP, 0 in IDLE.

Reset
REQ-025 With reset=0 at a rising edge: state=IDLE, shift register=0, counters=0, words_sent=0.
REQ-026 Output values after reset: n=0, bit_valid=0, done=0, busy=0, data_ready=1.
REQ-027 Reset asserted mid-SHIFT or mid-GAP SHALL abort the word at that edge; the partial word SHALL NOT count in words_sent and done SHALL NOT pulse.
REQ-028 data_valid with reset=0 SHALL be ignored; no word is accepted in a reset cycle.

Verification
REQ-029 Reset, then data_in=8'b1011_0110 valid one cycle -> n = 1,0,1,1,0,1,1,0 on the next 8 cycles, bit_valid=1 on all 8, done on the 8th, words_sent=1.
REQ-030 Two words back-to-back with data_valid held high, GAP=1 -> exactly one n=0/bit_valid=0 gap cycle plus one IDLE cycle between words; second accept 10 cycles after the first.
REQ-031 data_valid toggled and data_in changed during SHIFT -> serialized word unchanged, no extra accept, data_ready stays 0 until IDLE.
REQ-032 Reset=0 during the 4th bit of a word -> next cycle n=0, busy=0, data_ready=1, words_sent unchanged, no done pulse.
REQ-033 256 consecutive words -> words_sent reads 255 after word 255, 0 after word 256.
REQ-034 Stream 1011 into the team's sequence detector via n (GAP=0, WIDTH=4) -> detector output asserts once per word at the expected bit.
